// File: rtl/float_pkg.sv
// float_pkg: shared float lane type, default lane width and gather bank state encoding.
package float_pkg;
  localparam int FBITS = 18;
  typedef logic [FBITS-1:0] float_t;
  typedef enum logic {FILL, FULL} gather_state_e;
endpackage

// File: rtl/float_gather_bank.sv
// float_gather_bank: one gather bank -- lane storage, written-lane mask, slot counter and FILL/FULL FSM.
module float_gather_bank import float_pkg::*; #(
  parameter int WIDTH_IN  = 4,
  parameter int WIDTH_OUT = 16,
  parameter int FBITS     = float_pkg::FBITS
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [WIDTH_IN-1:0][FBITS-1:0]  i_in,
  input  logic                            i_wr,
  input  logic                            i_last,
  input  logic                            i_rd,
  output logic [WIDTH_OUT-1:0][FBITS-1:0] o_out,
  output logic [WIDTH_OUT-1:0]            o_mask,
  output logic                            o_full
);
  localparam int RATIO = WIDTH_OUT / WIDTH_IN;
  localparam int CW = RATIO > 1 ? $clog2(RATIO) : 1;
  gather_state_e r_state;
  logic [CW-1:0] r_cnt;
  logic [WIDTH_OUT-1:0][FBITS-1:0] r_data;
  logic [WIDTH_OUT-1:0] r_mask;
  logic w_fill, w_done;
  assign w_fill = r_state == FILL;
  assign w_done = i_last || r_cnt == CW'(RATIO - 1);
  assign o_full = !w_fill;
  assign o_mask = r_mask;
  // data lanes are never cleared; the mask alone decides which lanes are visible
  always_comb begin
    o_out = '0;
    for (int i = 0; i < WIDTH_OUT; i++) if (r_mask[i]) o_out[i] = r_data[i];
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= FILL;
      r_cnt   <= '0;
      r_data  <= '0;
      r_mask  <= '0;
    end else if (w_fill) begin
      if (i_wr) begin
        for (int s = 0; s < RATIO; s++)
          if (r_cnt == CW'(s)) begin
            r_data[s*WIDTH_IN +: WIDTH_IN] <= i_in;
            r_mask[s*WIDTH_IN +: WIDTH_IN] <= '1;
          end
        r_cnt <= w_done ? '0 : r_cnt + 1'b1;
        if (w_done) r_state <= FULL;
      end
    end else if (i_rd) begin
      r_mask  <= '0;
      r_state <= FILL;
    end
endmodule

// File: rtl/float_gather.sv
// float_gather: reassembles WIDTH_IN-lane beats into WIDTH_OUT-lane vectors behind valid/ready.
// FLOAT_GATHER_PINGPONG_EN adds a second bank so one bank fills while the other drains.
module float_gather import float_pkg::*; #(
  parameter int WIDTH_IN  = 4,
  parameter int WIDTH_OUT = 16,
  parameter int FBITS     = float_pkg::FBITS
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [WIDTH_IN-1:0][FBITS-1:0]  in,
  input  logic                            in_valid,
  input  logic                            in_last,
  output logic                            in_ready,
  output logic [WIDTH_OUT-1:0][FBITS-1:0] out,
  output logic [WIDTH_OUT-1:0]            out_mask,
  output logic                            out_valid,
  input  logic                            out_ready
);
  logic w_acc, w_hs;
  assign w_acc = in_valid && in_ready;
  assign w_hs  = out_valid && out_ready;
`ifdef FLOAT_GATHER_PINGPONG_EN
  logic r_wr_sel, r_rd_sel, w_ws;
  logic [1:0][WIDTH_OUT-1:0][FBITS-1:0] w_out;
  logic [1:0][WIDTH_OUT-1:0] w_mask;
  logic [1:0] w_full;
  // the cycle after a bank completes, beats already steer to the other bank
  assign w_ws      = r_wr_sel ^ w_full[r_wr_sel];
  assign in_ready  = !(&w_full);
  assign out_valid = w_full[r_rd_sel];
  assign out       = w_out[r_rd_sel];
  assign out_mask  = w_mask[r_rd_sel];
  for (genvar g = 0; g < 2; g++) begin : g_bank
    float_gather_bank #(.WIDTH_IN(WIDTH_IN), .WIDTH_OUT(WIDTH_OUT), .FBITS(FBITS)) u_bank (
      .clk(clk), .rst_n(rst_n), .i_in(in),
      .i_wr(w_acc && w_ws == 1'(g)), .i_last(in_last),
      .i_rd(w_hs && r_rd_sel == 1'(g)),
      .o_out(w_out[g]), .o_mask(w_mask[g]), .o_full(w_full[g])
    );
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_wr_sel <= 1'b0;
      r_rd_sel <= 1'b0;
    end else begin
      if (in_ready) r_wr_sel <= w_ws;
      if (w_hs) r_rd_sel <= !r_rd_sel;
    end
`else
  logic w_full;
  assign in_ready  = !w_full;
  assign out_valid = w_full;
  float_gather_bank #(.WIDTH_IN(WIDTH_IN), .WIDTH_OUT(WIDTH_OUT), .FBITS(FBITS)) u_bank (
    .clk(clk), .rst_n(rst_n), .i_in(in),
    .i_wr(w_acc), .i_last(in_last), .i_rd(w_hs),
    .o_out(out), .o_mask(out_mask), .o_full(w_full)
  );
`endif
endmodule

// File: tb/tb_float_gather.sv
// tb_float_gather: table-driven, hand-written and randomized scoreboard checks of float_gather.
module tb_float_gather;
  localparam int WI = 4, WO = 16, FB = 18, R = WO / WI;
  typedef struct {int nb; int base; logic l; logic [WO-1:0] mask;} tv_t;
  typedef struct {logic [WO-1:0][FB-1:0] d; logic [WO-1:0] m;} vec_t;
  logic clk = 0, rst_n = 0;
  logic [WI-1:0][FB-1:0] in = '0;
  logic in_valid = 0, in_last = 0, in_ready, out_valid, out_ready = 0;
  logic [WO-1:0][FB-1:0] out;
  logic [WO-1:0] out_mask;
  int n_chk = 0, n_fail = 0;
  tv_t tv[6];
  vec_t q[$];

  float_gather #(.WIDTH_IN(WI), .WIDTH_OUT(WO), .FBITS(FB)) dut (
    .clk(clk), .rst_n(rst_n), .in(in), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .out(out), .out_mask(out_mask), .out_valid(out_valid),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [WO*FB-1:0] act, input logic [WO*FB-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [WI-1:0][FB-1:0] beat(input int base, input int k);
    logic [WI-1:0][FB-1:0] b;
    for (int j = 0; j < WI; j++) b[j] = FB'(base + k * WI + j);
    return b;
  endfunction

  function automatic logic [WO-1:0][FB-1:0] vec(input int base, input logic [WO-1:0] m);
    logic [WO-1:0][FB-1:0] v;
    for (int i = 0; i < WO; i++) v[i] = m[i] ? FB'(base + i) : '0;
    return v;
  endfunction

  task automatic send(input logic [WI-1:0][FB-1:0] d, input logic l);
    int n = 0;
    in = d; in_last = l; in_valid = 1;
    while (!in_ready && n < 50) begin step(); n++; end
    if (!in_ready) chk("send_timeout", in_ready, 1);
    step();
  endtask

  initial begin
    tv[0] = '{4, 'h100, 1'b0, 16'hFFFF};
    tv[1] = '{2, 'h200, 1'b1, 16'h00FF};
    tv[2] = '{1, 'h300, 1'b1, 16'h000F};
    tv[3] = '{3, 'h400, 1'b1, 16'h0FFF};
    tv[4] = '{4, 'h700, 1'b1, 16'hFFFF};
    tv[5] = '{1, 'h800, 1'b1, 16'h000F};
    step(); step();
    rst_n = 1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_mask", out_mask, 0);
    chk("rst_out", out, 0);

    // full vector, in_ready low for a single cycle in the base build
    out_ready = 1;
    for (int k = 0; k < R; k++) begin
      send(beat('h100, k), 0);
      if (k < R - 1) chk("full_early_valid", out_valid, 0);
    end
    in_valid = 0;
    chk("full_valid", out_valid, 1);
    chk("full_mask", out_mask, 16'hFFFF);
    chk("full_out", out, vec('h100, 16'hFFFF));
`ifdef FLOAT_GATHER_PINGPONG_EN
    chk("full_in_ready", in_ready, 1);
`else
    chk("full_in_ready", in_ready, 0);
`endif
    step();
    chk("full_after_valid", out_valid, 0);
    chk("full_after_ready", in_ready, 1);

    // table: beat counts, early last, last on the final slot
    for (int t = 0; t < 6; t++) begin
      out_ready = 0;
      for (int k = 0; k < tv[t].nb; k++) send(beat(tv[t].base, k), tv[t].l && k == tv[t].nb - 1);
      in_valid = 0; in_last = 0;
      chk("tbl_valid", out_valid, 1);
      chk("tbl_mask", out_mask, tv[t].mask);
      chk("tbl_out", out, vec(tv[t].base, tv[t].mask));
      out_ready = 1;
      step();
      out_ready = 0;
      chk("tbl_drain_valid", out_valid, 0);
      chk("tbl_drain_ready", in_ready, 1);
    end

    // backpressure
    out_ready = 0;
    for (int k = 0; k < R; k++) send(beat('h900, k), 0);
    in_valid = 0;
    for (int c = 0; c < 10; c++) begin
      chk("bp_valid", out_valid, 1);
      chk("bp_out", out, vec('h900, 16'hFFFF));
`ifdef FLOAT_GATHER_PINGPONG_EN
      chk("bp_in_ready", in_ready, 1);
`else
      chk("bp_in_ready", in_ready, 0);
`endif
      step();
    end
`ifdef FLOAT_GATHER_PINGPONG_EN
    for (int k = 0; k < R; k++) send(beat('hA00, k), 0);
    in_valid = 0;
    chk("bp_pp_full", in_ready, 0);
    chk("bp_pp_out", out, vec('h900, 16'hFFFF));
    out_ready = 1;
    step();
    chk("bp_pp_second_valid", out_valid, 1);
    chk("bp_pp_second_out", out, vec('hA00, 16'hFFFF));
`endif
    out_ready = 1;
    step();
    chk("bp_drain", out_valid, 0);

    // reset mid-vector
    out_ready = 0;
    send(beat('hB00, 0), 0);
    send(beat('hB00, 1), 0);
    in_valid = 0;
    #2 rst_n = 0;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_mask", out_mask, 0);
    chk("mid_rst_out", out, 0);
    step();
    rst_n = 1;
    chk("mid_rst_ready", in_ready, 1);
    for (int k = 0; k < R; k++) send(beat('hC00, k), 0);
    in_valid = 0;
    chk("post_rst_mask", out_mask, 16'hFFFF);
    chk("post_rst_out", out, vec('hC00, 16'hFFFF));
    out_ready = 1;
    step();

    // streaming, 8 back-to-back beats
    begin : t5
      int beats, vi, bub;
      bit a;
      bit ov[14];
      beats = 0; vi = 0; bub = 0;
      out_ready = 1;
      for (int c = 1; c <= 12; c++) begin
        ov[c] = out_valid;
        if (out_valid) begin
          chk("stream_out", out, vec('hD00 + vi * WO, 16'hFFFF));
          vi++;
        end
        if (beats < 2 * R) begin
          in = beat('hD00, beats); in_last = 0; in_valid = 1;
          if (!in_ready) bub++;
          a = in_ready;
        end else begin
          in_valid = 0;
          a = 0;
        end
        step();
        if (a) beats++;
      end
      chk("stream_v1", ov[5], 1);
      chk("stream_count", vi, 2);
`ifdef FLOAT_GATHER_PINGPONG_EN
      chk("stream_v2", ov[9], 1);
      chk("stream_bubbles", bub, 0);
`else
      chk("stream_v2", ov[10], 1);
      chk("stream_bubbles", bub, 1);
`endif
    end

    // randomized valid/ready against a queue model
    rst_n = 0;
    in_valid = 0;
    out_ready = 0;
    step();
    rst_n = 1;
    begin : t6
      logic [WO-1:0][FB-1:0] cd;
      logic [WO-1:0] cm;
      int slot, done, cyc;
      bit acc, hs, hold;
      cd = '0; cm = '0; slot = 0; done = 0; cyc = 0; hold = 0;
      while (done < 1000 && cyc < 40000) begin
        chk("rnd_out_valid", out_valid, q.size() != 0);
`ifdef FLOAT_GATHER_PINGPONG_EN
        chk("rnd_in_ready", in_ready, q.size() < 2);
`else
        chk("rnd_in_ready", in_ready, q.size() == 0);
`endif
        if (!hold) begin
          in_valid = $urandom_range(0, 9) < 7;
          for (int j = 0; j < WI; j++) in[j] = FB'($urandom);
          in_last = $urandom_range(0, 3) == 0;
        end
        out_ready = $urandom_range(0, 9) < 6;
        acc = in_valid && in_ready;
        hs = out_valid && out_ready;
        if (hs && q.size() > 0) begin
          chk("rnd_data", out, q[0].d);
          chk("rnd_mask", out_mask, q[0].m);
          void'(q.pop_front());
          done++;
        end
        if (acc) begin
          for (int j = 0; j < WI; j++) begin
            cd[slot * WI + j] = in[j];
            cm[slot * WI + j] = 1'b1;
          end
          slot++;
          if (slot == R || in_last) begin
            q.push_back('{cd, cm});
            cd = '0; cm = '0; slot = 0;
          end
        end
        hold = in_valid && !acc;
        step();
        cyc++;
      end
      chk("rnd_vectors", done, 1000);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
